seq_acceptor: RTL and testbench

//   Parametrised key-sequence acceptor, successor to the fixed 8-step d-pad code FSM.
//   - Accepts N-key input, a runtime-programmable sequence of SEQ_LEN steps, and an idle timeout.
//   - Adds failed-attempt lockout.
//   - Sits after the per-key debouncers; drives status to the display coder and game logic.

---
 rtl/seq_acceptor.sv | 103 ++++++++++
 tb/tb_seq_acceptor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_acceptor.sv
// seq_acceptor: programmable N-key release-sequence acceptor with idle timeout and failed-attempt lockout
module seq_acceptor #(
    parameter int NUM_KEYS = 4,
    parameter int KEY_W = 2,
    parameter int SEQ_LEN = 8,
    parameter logic [SEQ_LEN*KEY_W-1:0] DEFAULT_SEQ = 16'hEE50,
    parameter int TIMEOUT_W = 25,
    parameter int MAX_FAILS = 3,
    parameter int LOCK_W = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic                prog_we,
    input  logic [3:0]          prog_idx,
    input  logic [KEY_W-1:0]    prog_key,
    output logic                prog_err,
    output logic [2:0]          state,
    output logic [4:0]          progress,
    output logic                accept_pulse,
    output logic                reject_pulse,
    output logic [3:0]          fail_cnt
);
    typedef enum logic [2:0] {IDLE = 3'd0, MATCH = 3'd1, ACCEPT = 3'd2, REJECT = 3'd3, LOCKED = 3'd4} state_t;
    localparam logic [4:0] LEN = 5'(SEQ_LEN);
    localparam logic [3:0] MF = 4'(MAX_FAILS);

    state_t st;
    logic [KEY_W-1:0] seq [SEQ_LEN];
    logic [NUM_KEYS-1:0] p1, p2, rel;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [LOCK_W-1:0] lcnt;
    logic [KEY_W-1:0] k, want;
    logic single, hit, to, wr_ok;
    logic [4:0] np;
    logic [3:0] nf;

    assign rel = p2 & ~p1;
    assign single = $onehot(rel);
    assign state = st;
    assign to = &tcnt && st == MATCH;
    assign wr_ok = prog_we && st == IDLE && {1'b0, prog_idx} < LEN;
    assign hit = single && k == want && (st == IDLE || st == MATCH);
    assign np = progress + 5'd1;
    assign nf = fail_cnt + {3'd0, fail_cnt != 4'hf};

    // progress is 0 in IDLE, so the same lookup serves the first step and later ones
    always_comb begin
        k = '0;
        want = seq[0];
        for (int i = 0; i < NUM_KEYS; i++)
            if (rel[i]) k = KEY_W'(i);
        for (int i = 0; i < SEQ_LEN; i++)
            if (progress == 5'(i)) want = seq[i];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            p1 <= '0;
            p2 <= '0;
            tcnt <= '0;
        end else begin
            p1 <= ~keys_n;
            p2 <= p1;
            tcnt <= (|rel || st != MATCH) ? '0 : tcnt + TIMEOUT_W'(~&tcnt);
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            st <= IDLE;
            progress <= '0;
            fail_cnt <= '0;
            lcnt <= '0;
            accept_pulse <= 1'b0;
            reject_pulse <= 1'b0;
            prog_err <= 1'b0;
            for (int i = 0; i < SEQ_LEN; i++) seq[i] <= DEFAULT_SEQ[i*KEY_W +: KEY_W];
        end else begin
            accept_pulse <= 1'b0;
            reject_pulse <= 1'b0;
            prog_err <= prog_we && !wr_ok;
            lcnt <= st == LOCKED ? lcnt + LOCK_W'(1) : '0;
            for (int i = 0; i < SEQ_LEN; i++)
                if (wr_ok && prog_idx == 4'(i)) seq[i] <= prog_key;
            if (hit) begin
                progress <= np;
                st <= np == LEN ? ACCEPT : MATCH;
                accept_pulse <= np == LEN;
                fail_cnt <= np == LEN ? 4'd0 : fail_cnt;
            end else if (st == MATCH && (|rel || to)) begin
                fail_cnt <= nf;
                reject_pulse <= 1'b1;
                st <= (MF != 4'd0 && nf >= MF) ? LOCKED : REJECT;
                progress <= (MF != 4'd0 && nf >= MF) ? 5'd0 : progress;
            end else if ((st == ACCEPT || st == REJECT) && |rel) begin
                st <= IDLE;
                progress <= '0;
            end else if (st == LOCKED && &lcnt) begin
                st <= IDLE;
                fail_cnt <= '0;
            end
        end
endmodule

// File: tb/tb_seq_acceptor.sv
// tb_seq_acceptor: directed scenarios plus randomized key/programming traffic, scored against
// an event-level reference model (release events, arithmetic timeout/lockout deadlines).
module tb_seq_acceptor;
    localparam int TW = 5, LW = 5, MF = 3, SL = 8;

    logic clk = 1'b0, reset = 1'b0;
    logic [3:0] keys_n = 4'hf;
    logic prog_we = 1'b0;
    logic [3:0] prog_idx = 4'd0;
    logic [1:0] prog_key = 2'd0;
    logic prog_err, accept_pulse, reject_pulse;
    logic [2:0] state;
    logic [4:0] progress;
    logic [3:0] fail_cnt;

    always #5 clk = ~clk;

    seq_acceptor #(.NUM_KEYS(4), .KEY_W(2), .SEQ_LEN(SL), .DEFAULT_SEQ(16'hEE50),
                   .TIMEOUT_W(TW), .MAX_FAILS(MF), .LOCK_W(LW)) dut (
        .clk(clk), .reset(reset), .keys_n(keys_n), .prog_we(prog_we), .prog_idx(prog_idx),
        .prog_key(prog_key), .prog_err(prog_err), .state(state), .progress(progress),
        .accept_pulse(accept_pulse), .reject_pulse(reject_pulse), .fail_cnt(fail_cnt));

    int checks = 0, failures = 0, ecount = 0;
    bit started = 0;
    int ms, mprog, mfail, last_hit, lock_e;
    int mseq [SL];
    typedef struct {int e; logic [2:0] kind;} ev_t;
    ev_t q [$];
    logic [3:0] rel_at [int];

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, got, exp, ecount);
        end
    endtask

    task automatic expect_now(string name, int s, int p, int f);
        check({name, ".state"}, state, s);
        check({name, ".progress"}, progress, p);
        check({name, ".fail_cnt"}, fail_cnt, f);
    endtask

    function automatic void model_reset();
        ms = 0; mprog = 0; mfail = 0; last_hit = 0; lock_e = 0;
        mseq = '{0, 0, 1, 1, 2, 3, 2, 3};
        q.delete();
        rel_at.delete();
    endfunction

    // one FSM edge: r = keys whose release is seen on this edge; kind = {prog_err, reject, accept}
    function automatic void model_step(logic we, logic [3:0] idx, logic [1:0] key);
        logic [3:0] r;
        logic [2:0] kind;
        int k;
        bit wr;
        r = 4'd0;
        if (rel_at.exists(ecount)) begin
            r = rel_at[ecount];
            rel_at.delete(ecount);
        end
        kind = 3'd0;
        k = -1;
        if ($countones(r) == 1)
            for (int i = 0; i < 4; i++) if (r[i]) k = i;
        wr = we && ms == 0 && int'(idx) < SL;
        if (we && !wr) kind[2] = 1'b1;
        if ((ms == 0 || ms == 1) && k >= 0 && k == mseq[mprog]) begin
            mprog++;
            last_hit = ecount;
            if (mprog == SL) begin ms = 2; mfail = 0; kind[0] = 1'b1; end
            else ms = 1;
        end else if (ms == 1 && (r != 0 || ecount - last_hit >= (1 << TW))) begin
            mfail = mfail < 15 ? mfail + 1 : 15;
            kind[1] = 1'b1;
            if (MF != 0 && mfail >= MF) begin ms = 4; mprog = 0; lock_e = ecount; end
            else ms = 3;
        end else if ((ms == 2 || ms == 3) && r != 0) begin
            ms = 0; mprog = 0;
        end else if (ms == 4 && ecount - lock_e >= (1 << LW)) begin
            ms = 0; mfail = 0;
        end
        if (wr) mseq[int'(idx)] = int'(key);
        if (kind != 3'd0) q.push_back('{ecount, kind});
    endfunction

    task automatic tick();
        logic we;
        logic [3:0] idx;
        logic [1:0] key;
        we = prog_we; idx = prog_idx; key = prog_key;
        @(posedge clk);
        ecount++;
        if (!reset) model_step(we, idx, key);
        #1;
    endtask

    task automatic press_release(logic [3:0] m, int gap, logic pw = 1'b0, logic [3:0] pi = 4'd0, logic [1:0] pk = 2'd0);
        keys_n = keys_n & ~m;
        tick();
        tick();
        keys_n = keys_n | m;
        rel_at[ecount + 2] = (rel_at.exists(ecount + 2) ? rel_at[ecount + 2] : 4'd0) | m;
        tick();
        prog_we = pw; prog_idx = pi; prog_key = pk;
        tick();
        prog_we = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic prog(logic [3:0] idx, logic [1:0] key);
        prog_we = 1'b1; prog_idx = idx; prog_key = key;
        tick();
        prog_we = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] act;
        if (started && !reset) begin
            act = {prog_err, reject_pulse, accept_pulse};
            while (q.size() > 0 && q[0].e < ecount) begin
                checks++;
                failures++;
                $display("FAIL missed_event: got none expected kind %0d from edge %0d", q[0].kind, q[0].e);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].e == ecount) begin
                check("event_kind", act, q[0].kind);
                void'(q.pop_front());
            end else check("no_event", act, 0);
            check("state", state, ms);
            check("progress", progress, mprog);
            check("fail_cnt", fail_cnt, mfail);
        end
    end

    initial begin
        int keys1 [8];
        int r, a, b;
        logic [3:0] m;
        keys1 = '{0, 0, 1, 1, 2, 3, 2, 3};
        #1 reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        started = 1;
        expect_now("reset", 0, 0, 0);
        check("reset_pulses", {prog_err, reject_pulse, accept_pulse}, 0);

        foreach (keys1[i]) press_release(4'(1 << keys1[i]), 8);
        expect_now("default_accept", 2, 8, 0);
        press_release(4'b0010, 2);
        expect_now("accept_exit", 0, 0, 0);

        press_release(4'b0001, 3);
        press_release(4'b0001, 3);
        press_release(4'b0100, 3);
        expect_now("wrong_key", 3, 2, 1);
        press_release(4'b0001, 2);
        expect_now("reject_exit", 0, 0, 1);

        press_release(4'b0001, 2);
        repeat (40) tick();
        expect_now("timeout", 3, 1, 2);
        press_release(4'b0001, 2);

        press_release(4'b0001, 2);
        press_release(4'b1000, 2);
        expect_now("lockout", 4, 0, 3);
        press_release(4'b0001, 2);
        press_release(4'b0001, 2);
        expect_now("lock_ignores", 4, 0, 3);
        repeat (20) tick();
        expect_now("unlock", 0, 0, 0);

        prog(4'd0, 2'd3);
        prog(4'd9, 2'd1);
        press_release(4'b1000, 2);
        expect_now("prog_match", 1, 1, 0);
        prog(4'd2, 2'd0);
        for (int i = 1; i < 8; i++) press_release(4'(1 << keys1[i]), 2);
        expect_now("prog_accept", 2, 8, 0);
        press_release(4'b0001, 2);
        press_release(4'b1000, 2, 1'b1, 4'd0, 2'd1);
        expect_now("prewrite_compare", 1, 1, 0);
        press_release(4'b0011, 2);
        expect_now("double_release", 3, 1, 1);
        press_release(4'b0100, 2);
        press_release(4'b0010, 2);
        expect_now("reprog_match", 1, 1, 1);

        #2 reset = 1'b1;
        model_reset();
        #1 expect_now("async_reset", 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        press_release(4'b0001, 2);
        expect_now("default_restored", 1, 1, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 3);
            if (r < 8) prog(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            else if (r < 12) repeat (36) tick();
            else begin
                if (r < 70 && ms <= 1) m = 4'(1 << mseq[mprog]);
                else if (r < 80) begin
                    b = (a + 1 + $urandom_range(0, 2)) % 4;
                    m = 4'((1 << a) | (1 << b));
                end else m = 4'(1 << a);
                press_release(m, $urandom_range(0, 8), $urandom_range(0, 9) == 0,
                              4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            end
        end
        repeat (4) tick();
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
